// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one memory port between instruction fetch (inst_*) and the MEM
//   stage (data_*). Only one bus transaction is outstanding at a time. Each
//   transaction moves through three steps: the request is latched, it is
//   handshaken onto the bus, and the response is returned to its owner.
//   Data requests win by default. A streak counter bounds how long a waiting
//   fetch can be starved. cancle from EXE kills an in-flight fetch so that
//   wrong-path instructions never reach IF.
//
// Handshake rule (all *_valid / *_ready pairs):
//   A transfer happens in a cycle where valid and ready are both high at the
//   rising clock edge. After a source raises valid it keeps valid and the
//   payload stable until that transfer happens. The ready signals of this
//   block are combinational from the current state and inputs.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   cancle              EXE redirect; kills a pending or in-flight fetch
//   inst_req_*          fetch request (valid/ready, addr)
//   inst_resp_*         fetch response (valid/ready, data)
//   data_req_*          load/store request (valid/ready, addr, wen, wstrb, wdata)
//   data_resp_*         load data / store ack (valid/ready, data)
//   bus_req_*           memory request (valid/ready, addr, wen, wstrb, wdata)
//   bus_resp_*          memory response (valid/ready, data)
//   dbg_state_o         current FSM state (0 IDLE, 1 REQ, 2 RESP)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WD         = 32,
  parameter int DATA_WD         = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cancle,
  input  logic                 inst_req_valid,
  output logic                 inst_req_ready,
  input  logic [ADDR_WD-1:0]   inst_req_addr,
  output logic                 inst_resp_valid,
  input  logic                 inst_resp_ready,
  output logic [DATA_WD-1:0]   inst_resp_data,
  input  logic                 data_req_valid,
  output logic                 data_req_ready,
  input  logic [ADDR_WD-1:0]   data_req_addr,
  input  logic                 data_req_wen,
  input  logic [DATA_WD/8-1:0] data_req_wstrb,
  input  logic [DATA_WD-1:0]   data_req_wdata,
  output logic                 data_resp_valid,
  input  logic                 data_resp_ready,
  output logic [DATA_WD-1:0]   data_resp_data,
  output logic                 bus_req_valid,
  input  logic                 bus_req_ready,
  output logic [ADDR_WD-1:0]   bus_req_addr,
  output logic                 bus_req_wen,
  output logic [DATA_WD/8-1:0] bus_req_wstrb,
  output logic [DATA_WD-1:0]   bus_req_wdata,
  input  logic                 bus_resp_valid,
  output logic                 bus_resp_ready,
  input  logic [DATA_WD-1:0]   bus_resp_data,
  output logic [1:0]           dbg_state_o
);

  localparam int STRB_WD = DATA_WD / 8;
  localparam int SW      = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               owner_inst_q, owner_inst_d;
  logic               drop_q, drop_d;
  logic [SW-1:0]      streak_q, streak_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic               wen_q, wen_d;
  logic [STRB_WD-1:0] wstrb_q, wstrb_d;
  logic [DATA_WD-1:0] wdata_q, wdata_d;

  logic inst_elig;
  logic favour_inst;
  logic grant_inst;
  logic grant_data;
  logic inst_rdy_c;
  logic data_rdy_c;
  logic kill_resp;

  // A fetch is only eligible when EXE is not redirecting this cycle.
  assign inst_elig   = inst_req_valid && !cancle;
  // Once the data streak hits its limit, a waiting fetch takes priority.
  assign favour_inst = (streak_q == STREAK_MAX) && inst_elig;
  assign grant_data  = data_req_valid && !favour_inst;
  assign grant_inst  = inst_elig && (favour_inst || !data_req_valid);
  // The response of a fetch is discarded if it was cancelled earlier or is
  // being cancelled this very cycle.
  assign kill_resp   = drop_q || cancle;

  always_comb begin
    state_d         = state_q;
    owner_inst_d    = owner_inst_q;
    drop_d          = drop_q;
    streak_d        = streak_q;
    addr_d          = addr_q;
    wen_d           = wen_q;
    wstrb_d         = wstrb_q;
    wdata_d         = wdata_q;
    inst_rdy_c      = 1'b0;
    data_rdy_c      = 1'b0;
    bus_req_valid   = 1'b0;
    bus_resp_ready  = 1'b0;
    inst_resp_valid = 1'b0;
    data_resp_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          data_rdy_c   = 1'b1;
          owner_inst_d = 1'b0;
          addr_d       = data_req_addr;
          wen_d        = data_req_wen;
          wstrb_d      = data_req_wstrb;
          wdata_d      = data_req_wdata;
          state_d      = S_REQ;
        end else if (grant_inst) begin
          inst_rdy_c   = 1'b1;
          owner_inst_d = 1'b1;
          addr_d       = inst_req_addr;
          wen_d        = 1'b0;
          wstrb_d      = '0;
          wdata_d      = '0;
          state_d      = S_REQ;
        end
        // The streak counts data grants taken while a fetch was waiting.
        if (grant_data && inst_req_valid) begin
          if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (grant_inst || !inst_req_valid) begin
          streak_d = '0;
        end
      end

      S_REQ: begin
        bus_req_valid = 1'b1;
        // The request has already been committed, so it still goes to the
        // bus. Only its response is thrown away.
        if (owner_inst_q && cancle) begin
          drop_d = 1'b1;
        end
        if (bus_req_ready) begin
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (!owner_inst_q) begin
          data_resp_valid = bus_resp_valid;
          bus_resp_ready  = data_resp_ready;
        end else if (kill_resp) begin
          bus_resp_ready  = 1'b1;
          drop_d          = 1'b1;
        end else begin
          inst_resp_valid = bus_resp_valid;
          bus_resp_ready  = inst_resp_ready;
        end
        if (bus_resp_valid && bus_resp_ready) begin
          drop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // While reset is low the FSM sits in IDLE. Arbitration could still see
  // valid inputs there, so the request readies are masked to keep every
  // handshake output low during reset.
  assign inst_req_ready = inst_rdy_c && rst;
  assign data_req_ready = data_rdy_c && rst;

  assign bus_req_addr   = addr_q;
  assign bus_req_wen    = wen_q;
  assign bus_req_wstrb  = wstrb_q;
  assign bus_req_wdata  = wdata_q;
  assign inst_resp_data = bus_resp_data;
  assign data_resp_data = bus_resp_data;
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      owner_inst_q <= 1'b0;
      drop_q       <= 1'b0;
      streak_q     <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_inst_q <= owner_inst_d;
      drop_q       <= drop_d;
      streak_q     <= streak_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int PW = 69;  // {wen, wstrb[3:0], addr[31:0], wdata[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        cancle;
  logic        inst_req_valid, inst_req_ready;
  logic [31:0] inst_req_addr;
  logic        inst_resp_valid, inst_resp_ready;
  logic [31:0] inst_resp_data;
  logic        data_req_valid, data_req_ready;
  logic [31:0] data_req_addr;
  logic        data_req_wen;
  logic [3:0]  data_req_wstrb;
  logic [31:0] data_req_wdata;
  logic        data_resp_valid, data_resp_ready;
  logic [31:0] data_resp_data;
  logic        bus_req_valid, bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_wen;
  logic [3:0]  bus_req_wstrb;
  logic [31:0] bus_req_wdata;
  logic        bus_resp_valid, bus_resp_ready;
  logic [31:0] bus_resp_data;
  logic [1:0]  dbg_state_o;

  logic [PW-1:0] exp_q[$];
  logic [31:0]   exp_resp_q[$];
  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(.ADDR_WD(32), .DATA_WD(32), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst), .cancle(cancle),
    .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_req_addr(inst_req_addr),
    .inst_resp_valid(inst_resp_valid), .inst_resp_ready(inst_resp_ready),
    .inst_resp_data(inst_resp_data),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_req_addr(data_req_addr), .data_req_wen(data_req_wen),
    .data_req_wstrb(data_req_wstrb), .data_req_wdata(data_req_wdata),
    .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready),
    .data_resp_data(data_resp_data),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_req_addr(bus_req_addr), .bus_req_wen(bus_req_wen),
    .bus_req_wstrb(bus_req_wstrb), .bus_req_wdata(bus_req_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_resp_ready(bus_resp_ready),
    .bus_resp_data(bus_resp_data),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cancle = 0; inst_req_valid = 0; inst_req_addr = '0; inst_resp_ready = 1;
    data_req_valid = 0; data_req_addr = '0; data_req_wen = 0;
    data_req_wstrb = '0; data_req_wdata = '0; data_resp_ready = 1;
    bus_req_ready = 0; bus_resp_valid = 0; bus_resp_data = '0;
  endtask

  // ---------------- driver: bus side of one granted transaction ----------------
  // Called at posedge+1 right after the grant cycle.
  task automatic serve_bus(input int req_wait, input int resp_wait, input int stall,
                           input logic [31:0] rdata, input bit owner_inst,
                           output int n_wait);
    logic [PW-1:0] exp_p, got_p;
    logic [31:0]   exp_d;
    int n;
    n = 0;
    @(negedge clk);
    while (bus_req_valid !== 1'b1 && n < 20) begin
      step(); @(negedge clk); n++;
    end
    n_wait = n;
    checks++;
    if (bus_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL bus_req_timeout: bus_req_valid=%b after %0d cycles, required 1", bus_req_valid, n);
      return;
    end
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    got_p = {bus_req_wen, bus_req_wstrb, bus_req_addr, bus_req_wdata};
    checks++;
    if (got_p !== exp_p) begin
      failures++;
      $display("FAIL bus_req_payload: got=%h required=%h", got_p, exp_p);
    end
    checks++;
    if ({inst_req_ready, data_req_ready} !== 2'b00) begin
      failures++;
      $display("FAIL req_ready_busy: got=%b required=00", {inst_req_ready, data_req_ready});
    end
    for (int i = 0; i < req_wait; i++) begin
      step(); @(negedge clk);
      got_p = {bus_req_wen, bus_req_wstrb, bus_req_addr, bus_req_wdata};
      checks++;
      if (bus_req_valid !== 1'b1 || got_p !== exp_p) begin
        failures++;
        $display("FAIL bus_req_hold: valid=%b payload=%h required valid=1 payload=%h", bus_req_valid, got_p, exp_p);
      end
    end
    bus_req_ready = 1;
    step();
    bus_req_ready = 0;
    for (int i = 0; i < resp_wait; i++) begin
      @(negedge clk);
      checks++;
      if ({inst_resp_valid, data_resp_valid} !== 2'b00) begin
        failures++;
        $display("FAIL resp_early: got=%b required=00", {inst_resp_valid, data_resp_valid});
      end
      step();
    end
    bus_resp_valid = 1;
    bus_resp_data  = rdata;
    exp_resp_q.push_back(rdata);
    if (stall > 0) begin
      if (owner_inst) inst_resp_ready = 0; else data_resp_ready = 0;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if ((owner_inst ? inst_resp_valid : data_resp_valid) !== 1'b1 || bus_resp_ready !== 1'b0) begin
        failures++;
        $display("FAIL resp_stall: resp_valid=%b bus_resp_ready=%b required 1/0",
                 owner_inst ? inst_resp_valid : data_resp_valid, bus_resp_ready);
      end
      step();
    end
    inst_resp_ready = 1;
    data_resp_ready = 1;
    @(negedge clk);
    exp_d = exp_resp_q.pop_front();
    checks++;
    if (owner_inst ? ({inst_resp_valid, data_resp_valid, inst_resp_data} !== {2'b10, exp_d})
                   : ({inst_resp_valid, data_resp_valid, data_resp_data} !== {2'b01, exp_d})) begin
      failures++;
      $display("FAIL resp_return: inst_v=%b data_v=%b idata=%h ddata=%h required owner_inst=%0b data=%h",
               inst_resp_valid, data_resp_valid, inst_resp_data, data_resp_data, owner_inst, exp_d);
    end
    checks++;
    if (bus_resp_ready !== 1'b1) begin
      failures++;
      $display("FAIL bus_resp_ready: got=%b required=1", bus_resp_ready);
    end
    step();
    bus_resp_valid = 0;
    bus_resp_data  = '0;
    checks++;
    if (dbg_state_o !== 2'd0) begin
      failures++;
      $display("FAIL back_to_idle: state=%0d required=0", dbg_state_o);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 0;
    inst_req_valid = 1; data_req_valid = 1;
    repeat (2) step();
    @(negedge clk);
    checks++;
    if ({inst_req_ready, data_req_ready, bus_req_valid, bus_resp_ready, inst_resp_valid, data_resp_valid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outs: got=%b required=000000",
               {inst_req_ready, data_req_ready, bus_req_valid, bus_resp_ready, inst_resp_valid, data_resp_valid});
    end
    checks++;
    if ({bus_req_addr, bus_req_wen, bus_req_wstrb, bus_req_wdata, dbg_state_o} !== '0) begin
      failures++;
      $display("FAIL reset_regs: addr=%h wen=%b wstrb=%h wdata=%h state=%0d required all 0",
               bus_req_addr, bus_req_wen, bus_req_wstrb, bus_req_wdata, dbg_state_o);
    end
    step();
    clear_inputs();
    rst = 1;
    step();
  endtask

  task automatic test_lone_fetch();
    int n;
    inst_req_valid = 1; inst_req_addr = 32'h100;
    @(negedge clk);
    checks++;
    if ({inst_req_ready, data_req_ready, bus_req_valid} !== 3'b100) begin
      failures++;
      $display("FAIL lone_grant: got=%b required=100", {inst_req_ready, data_req_ready, bus_req_valid});
    end
    exp_q.push_back({1'b0, 4'h0, 32'h100, 32'h0});
    step();
    inst_req_valid = 0;
    serve_bus(0, 2, 0, 32'h0000_0013, 1'b1, n);
    checks++;
    if (n !== 0) begin
      failures++;
      $display("FAIL lone_latency: bus_req_valid after %0d extra cycles, required 0", n);
    end
  endtask

  task automatic test_both_valid();
    int n;
    inst_req_valid = 1; inst_req_addr = 32'h180;
    data_req_valid = 1; data_req_addr = 32'h2000; data_req_wen = 0;
    data_req_wstrb = 4'h0; data_req_wdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({inst_req_ready, data_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL both_first: got=%b required=01", {inst_req_ready, data_req_ready});
    end
    exp_q.push_back({1'b0, 4'h0, 32'h2000, 32'h0});
    step();
    data_req_valid = 0;
    serve_bus(0, 0, 0, 32'h1111_2222, 1'b0, n);
    @(negedge clk);
    checks++;
    if ({inst_req_ready, data_req_ready} !== 2'b10) begin
      failures++;
      $display("FAIL both_second: got=%b required=10", {inst_req_ready, data_req_ready});
    end
    exp_q.push_back({1'b0, 4'h0, 32'h180, 32'h0});
    step();
    inst_req_valid = 0;
    serve_bus(0, 1, 0, 32'h3333_4444, 1'b1, n);
  endtask

  task automatic test_streak();
    int n;
    bit exp_inst;
    inst_req_valid = 1; inst_req_addr = 32'h400;
    data_req_valid = 1; data_req_wen = 0; data_req_wstrb = 4'h0; data_req_wdata = 32'h0;
    // Grants 0-3 data, 4 fetch (limit reached), 5 data again (streak cleared),
    // 6 fetch (data no longer requesting).
    for (int g = 0; g < 7; g++) begin
      data_req_addr = 32'h500 + 32'(g * 4);
      if (g == 5) inst_req_addr = 32'h404;
      if (g == 6) data_req_valid = 0;
      exp_inst = (g == 4) || (g == 6);
      @(negedge clk);
      checks++;
      if ({inst_req_ready, data_req_ready} !== (exp_inst ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL streak_grant%0d: got=%b required=%b", g, {inst_req_ready, data_req_ready},
                 exp_inst ? 2'b10 : 2'b01);
      end
      exp_q.push_back(exp_inst ? {1'b0, 4'h0, inst_req_addr, 32'h0}
                               : {1'b0, 4'h0, data_req_addr, 32'h0});
      step();
      if (g == 6) inst_req_valid = 0;
      serve_bus(0, 0, 0, $urandom, exp_inst, n);
    end
  endtask

  // phase 0: cancel in REQ; 1: cancel in RESP one cycle before the response;
  // 2: cancel in the same cycle as the response.
  task automatic test_cancel(input int phase);
    logic [PW-1:0] exp_p;
    inst_resp_ready = 0;  // the sink must not depend on IF being ready
    inst_req_valid = 1; inst_req_addr = 32'h300 + 32'(phase * 4);
    @(negedge clk);
    checks++;
    if (inst_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL cancel%0d_grant: got=%b required=1", phase, inst_req_ready);
    end
    exp_q.push_back({1'b0, 4'h0, inst_req_addr, 32'h0});
    step();
    inst_req_valid = 0;
    @(negedge clk);
    exp_p = exp_q.pop_front();
    checks++;
    if (bus_req_valid !== 1'b1 || {bus_req_wen, bus_req_wstrb, bus_req_addr, bus_req_wdata} !== exp_p) begin
      failures++;
      $display("FAIL cancel%0d_issue: valid=%b addr=%h required valid=1 addr=%h", phase,
               bus_req_valid, bus_req_addr, exp_p[63:32]);
    end
    if (phase == 0) cancle = 1;
    bus_req_ready = 1;
    step();
    cancle = 0; bus_req_ready = 0;
    if (phase == 1) begin
      cancle = 1;
      @(negedge clk);
      checks++;
      if ({inst_resp_valid, bus_resp_ready} !== 2'b01) begin
        failures++;
        $display("FAIL cancel%0d_pre: inst_resp_valid/bus_resp_ready=%b required=01", phase,
                 {inst_resp_valid, bus_resp_ready});
      end
      step();
      cancle = 0;
    end
    bus_resp_valid = 1; bus_resp_data = $urandom;
    if (phase == 2) cancle = 1;
    @(negedge clk);
    checks++;
    if ({inst_resp_valid, bus_resp_ready} !== 2'b01) begin
      failures++;
      $display("FAIL cancel%0d_sink: inst_resp_valid/bus_resp_ready=%b required=01", phase,
               {inst_resp_valid, bus_resp_ready});
    end
    step();
    bus_resp_valid = 0; cancle = 0; inst_resp_ready = 1;
    checks++;
    if (dbg_state_o !== 2'd0) begin
      failures++;
      $display("FAIL cancel%0d_idle: state=%0d required=0", phase, dbg_state_o);
    end
  endtask

  task automatic test_cancel_data();
    int n;
    // cancle in IDLE blocks only the fetch; data proceeds unaffected.
    cancle = 1; inst_req_valid = 1; inst_req_addr = 32'h600;
    @(negedge clk);
    checks++;
    if ({inst_req_ready, data_req_ready} !== 2'b00) begin
      failures++;
      $display("FAIL cancel_idle_block: got=%b required=00", {inst_req_ready, data_req_ready});
    end
    step();
    data_req_valid = 1; data_req_addr = 32'h700; data_req_wen = 0;
    data_req_wstrb = 4'h0; data_req_wdata = 32'h0;
    @(negedge clk);
    checks++;
    if ({inst_req_ready, data_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL cancel_data_grant: got=%b required=01", {inst_req_ready, data_req_ready});
    end
    exp_q.push_back({1'b0, 4'h0, 32'h700, 32'h0});
    step();
    data_req_valid = 0; inst_req_valid = 0;
    serve_bus(0, 1, 0, 32'hCAFE_0001, 1'b0, n);
    cancle = 0;
  endtask

  task automatic test_store_stall();
    int n;
    data_req_valid = 1; data_req_addr = 32'h200; data_req_wen = 1;
    data_req_wstrb = 4'hF; data_req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (data_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL store_grant: got=%b required=1", data_req_ready);
    end
    exp_q.push_back({1'b1, 4'hF, 32'h200, 32'hDEAD_BEEF});
    step();
    data_req_valid = 0; data_req_wen = 0; data_req_wstrb = 4'h0; data_req_wdata = 32'h0;
    serve_bus(3, 1, 2, 32'h0, 1'b0, n);
  endtask

  task automatic test_random();
    int n;
    bit is_inst;
    logic [31:0] a;
    for (int t = 0; t < 10; t++) begin
      is_inst = 1'($urandom_range(0, 1));
      a = {$urandom_range(0, 32'hFFFF), 2'b00, 14'h0} | 32'($urandom_range(0, 255) * 4);
      if (is_inst) begin
        inst_req_valid = 1; inst_req_addr = a;
        exp_q.push_back({1'b0, 4'h0, a, 32'h0});
      end else begin
        data_req_valid = 1; data_req_addr = a; data_req_wen = 1'($urandom_range(0, 1));
        data_req_wstrb = 4'($urandom_range(0, 15)); data_req_wdata = $urandom;
        exp_q.push_back({data_req_wen, data_req_wstrb, a, data_req_wdata});
      end
      @(negedge clk);
      checks++;
      if ({inst_req_ready, data_req_ready} !== (is_inst ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL rand%0d_grant: got=%b required=%b", t, {inst_req_ready, data_req_ready},
                 is_inst ? 2'b10 : 2'b01);
      end
      step();
      inst_req_valid = 0; data_req_valid = 0;
      serve_bus($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1), $urandom, is_inst, n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    inst_req_valid = 1; inst_req_addr = 32'h800;
    step();
    inst_req_valid = 0;
    @(negedge clk);
    checks++;
    if (bus_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_req: bus_req_valid=%b required=1", bus_req_valid);
    end
    #2;
    inst_req_valid = 1; data_req_valid = 1; data_req_addr = 32'h900;
    rst = 0;
    #1;
    checks++;
    if ({inst_req_ready, data_req_ready, bus_req_valid, bus_resp_ready, inst_resp_valid, data_resp_valid} !== 6'b0
        || bus_req_addr !== 32'h0 || dbg_state_o !== 2'd0) begin
      failures++;
      $display("FAIL rstmid_async: hs=%b addr=%h state=%0d required 000000/0/0",
               {inst_req_ready, data_req_ready, bus_req_valid, bus_resp_ready, inst_resp_valid, data_resp_valid},
               bus_req_addr, dbg_state_o);
    end
    exp_q.delete();
    step();
    clear_inputs();
    rst = 1;
    step();
    inst_req_valid = 1; inst_req_addr = 32'hA00;
    @(negedge clk);
    checks++;
    if (inst_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_regrant: got=%b required=1", inst_req_ready);
    end
    exp_q.push_back({1'b0, 4'h0, 32'hA00, 32'h0});
    step();
    inst_req_valid = 0;
    serve_bus(1, 1, 0, 32'h0050_0093, 1'b1, n);
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_lone_fetch();
    test_both_valid();
    test_streak();
    test_cancel(0);
    test_cancel(1);
    test_cancel(2);
    test_cancel_data();
    test_store_stall();
    test_random();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expected requests left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
